pipelined_barrel_shifter: RTL

Parametrised, pipelined barrel shifter: the successor to the 8-bit combinational shifter in the ALU datapath. It adds configurable width, logical, arithmetic and rotate modes, and one pipeline stage per shift-amount bit. A valid/ready handshake carries backpressure, and a sideband tag travels with each operand. It sits between the register-read stage and the ALU writeback mux of the lab CPU.

---
 rtl/pipelined_barrel_shifter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/pipelined_barrel_shifter.sv
// -----------------------------------------------------------------------------
// pipelined_barrel_shifter
//
// Pipelined barrel shifter for the lab CPU datapath. It sits between
// register-read and the ALU writeback mux. There is one register stage per
// shift-amount bit: stage k shifts by 2^k when its captured shamt[k] is set.
// It supports logical, arithmetic and rotate shifts plus a pass-through mode.
// A sideband tag travels with each operand.
//
// Flow control is a global stall. All stages advance together whenever the
// output slot is empty or being drained (en = out_ready | ~out_valid).
// Bubbles are not collapsed.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand valid
//   in_ready   shifter can accept an operand this cycle (== en)
//   in         operand, WIDTH bits
//   shamt      shift amount, SHW bits (all values legal)
//   dir        0 = right, 1 = left
//   mode       00 logical, 01 arithmetic, 10 rotate, 11 pass-through
//   tag        sideband, returned unchanged with the result
//   out_valid  result valid (last stage valid bit)
//   out_ready  consumer accepts the result
//   out        shifted result, straight from the last stage register
//   out_tag    tag of the result
//   out_zero   out == 0
// -----------------------------------------------------------------------------
module pipelined_barrel_shifter #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH),
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in,
  input  logic [SHW-1:0]   shamt,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic [TAG_W-1:0] tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero
);

  typedef enum logic [1:0] {
    MODE_LOGIC  = 2'b00,
    MODE_ARITH  = 2'b01,
    MODE_ROTATE = 2'b10,
    MODE_PASS   = 2'b11
  } mode_e;

  // One partial shift by a fixed amount. Arithmetic right shifts fill with the
  // sign of the ORIGINAL operand. An intermediate stage may already have
  // shifted the MSB away, so the sign is carried alongside the data.
  function automatic logic [WIDTH-1:0] f_shift(
    input logic [WIDTH-1:0] d,
    input int               amt,
    input logic             left,
    input mode_e            md,
    input logic             sgn
  );
    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] res;
    ones = '1;
    res  = d;
    if (amt != 0) begin
      case (md)
        MODE_LOGIC, MODE_ARITH: begin
          if (left) res = d << amt;
          else      res = (d >> amt) | (((md == MODE_ARITH) && sgn) ? ~(ones >> amt) : '0);
        end
        MODE_ROTATE: begin
          if (left) res = (d << amt) | (d >> (WIDTH - amt));
          else      res = (d >> amt) | (d << (WIDTH - amt));
        end
        default: res = d;
      endcase
    end
    return res;
  endfunction

  // Stage registers, packed per stage: index k is stage k.
  logic  [SHW-1:0][WIDTH-1:0] r_data;
  logic  [SHW-1:0][SHW-1:0]   r_shamt;
  logic  [SHW-1:0]            r_dir;
  mode_e [SHW-1:0]            r_mode;
  logic  [SHW-1:0]            r_sign;
  logic  [SHW-1:0][TAG_W-1:0] r_tag;
  logic  [SHW-1:0]            r_valid;

  // Source of each stage: the input ports for stage 0, else the previous stage.
  logic  [SHW-1:0][WIDTH-1:0] w_src_data;
  logic  [SHW-1:0][WIDTH-1:0] w_next_data;
  logic  [SHW-1:0][SHW-1:0]   w_src_shamt;
  logic  [SHW-1:0]            w_src_dir;
  mode_e [SHW-1:0]            w_src_mode;
  logic  [SHW-1:0]            w_src_sign;
  logic  [SHW-1:0][TAG_W-1:0] w_src_tag;
  logic  [SHW-1:0]            w_src_valid;
  logic                       w_en;

  // The last stage's control fields and the low shamt bits already consumed
  // by earlier stages are carried for uniformity but never read.
  logic                       w_unused;

  assign w_en     = out_ready | ~r_valid[SHW-1];
  assign w_unused = ^{r_shamt, r_dir[SHW-1], r_mode[SHW-1], r_sign[SHW-1]};

  // NOTE: every combinational output gets a value on every path (defaults
  // first, then the loop), so no latch can be inferred.
  always_comb begin
    w_src_data  = '0;
    w_src_shamt = '0;
    w_src_dir   = '0;
    w_src_mode  = '{default: MODE_LOGIC};
    w_src_sign  = '0;
    w_src_tag   = '0;
    w_src_valid = '0;
    w_next_data = '0;

    w_src_data[0]  = in;
    w_src_shamt[0] = shamt;
    w_src_dir[0]   = dir;
    w_src_mode[0]  = mode_e'(mode);
    w_src_sign[0]  = in[WIDTH-1];
    w_src_tag[0]   = tag;
    w_src_valid[0] = in_valid;

    for (int k = 1; k < SHW; k++) begin
      w_src_data[k]  = r_data[k-1];
      w_src_shamt[k] = r_shamt[k-1];
      w_src_dir[k]   = r_dir[k-1];
      w_src_mode[k]  = r_mode[k-1];
      w_src_sign[k]  = r_sign[k-1];
      w_src_tag[k]   = r_tag[k-1];
      w_src_valid[k] = r_valid[k-1];
    end

    for (int k = 0; k < SHW; k++) begin
      w_next_data[k] = f_shift(w_src_data[k], w_src_shamt[k][k] ? (1 << k) : 0,
                               w_src_dir[k], w_src_mode[k], w_src_sign[k]);
    end
  end

  // NOTE: the data registers are reset as well as the valid bits. The idle
  // output must read out=0 and out_zero=1, and a register-based pipeline this
  // small can afford an async reset on every flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_shamt <= '0;
      r_dir   <= '0;
      r_mode  <= '{default: MODE_LOGIC};
      r_sign  <= '0;
      r_tag   <= '0;
      r_valid <= '0;
    end else if (w_en) begin
      // NOTE: non-blocking assignments let every stage sample the previous
      // stage's old value on the same edge, which is what makes this a pipeline.
      r_data  <= w_next_data;
      r_shamt <= w_src_shamt;
      r_dir   <= w_src_dir;
      r_mode  <= w_src_mode;
      r_sign  <= w_src_sign;
      r_tag   <= w_src_tag;
      r_valid <= w_src_valid;
    end
  end

  assign in_ready  = w_en;
  assign out_valid = r_valid[SHW-1];
  assign out       = r_data[SHW-1];
  assign out_tag   = r_tag[SHW-1];
  assign out_zero  = (r_data[SHW-1] == '0);

endmodule
